pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register. It replaces the fixed-field inter-stage latches (ID/EX, EX/MEM, MEM/WB) with a single block that supports valid/ready handshaking, stall back-pressure, synchronous flush (bubble insertion), and an optional 2-entry skid buffer that breaks the ready path. Saturating stall and bubble counters support pipeline performance debug. Each stage instance packs its control fields into `in_ctrl` and its datapath fields (ALU out, PC+4, write register, write data, ...) into `in_data`.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy state
// encoding and the control/datapath bundle layouts of each inter-stage latch.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } stage_state_t;

    // ID/EX: ctrl = {lbflag, alu_op[2:0], mem_write, mem_read, mem_to_reg, reg_write}
    localparam int IDEX_CTRL_W    = 8;
    localparam int IDEX_DATA_W    = 101;
    localparam int IDEX_RD1_LSB   = 0;
    localparam int IDEX_RD2_LSB   = 32;
    localparam int IDEX_IMM_LSB   = 64;
    localparam int IDEX_WREG_LSB  = 96;

    // EX/MEM: {wreg, pc_plus4, write_data, alu_out}
    localparam int EXMEM_CTRL_W   = 8;
    localparam int EXMEM_DATA_W   = 101;
    localparam int EXMEM_ALU_LSB  = 0;
    localparam int EXMEM_WDAT_LSB = 32;
    localparam int EXMEM_PC4_LSB  = 64;
    localparam int EXMEM_WREG_LSB = 96;

    // MEM/WB: {wreg, pc_plus4, alu_out, mem_rdata}
    localparam int MEMWB_CTRL_W   = 8;
    localparam int MEMWB_DATA_W   = 101;
    localparam int MEMWB_RDAT_LSB = 0;
    localparam int MEMWB_ALU_LSB  = 32;
    localparam int MEMWB_PC4_LSB  = 64;
    localparam int MEMWB_WREG_LSB = 96;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall/bubble debug.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush, optional
// 2-entry skid buffer and saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_t      state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid_ready
            // Registered: decoded from state only, never from out_ready.
            assign in_ready = (state != ST_SKIDDED);
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // NOTE: the bundle registers are plain flops, not a RAM, so they are reset
    // to zero along with the state; a flushed or reset stage must read all-zero.
    always_ff @(posedge sysclk) begin
        if (reset || flush) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state     <= ST_FULL;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ST_FULL: begin
                    if (SKID && in_fire && !out_fire) begin
                        state     <= ST_SKIDDED;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (in_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (out_fire) begin
                        state     <= ST_EMPTY;
                        main_ctrl <= '0;
                    end
                end
                ST_SKIDDED: begin
                    if (out_fire) begin
                        state     <= ST_FULL;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                        skid_data <= '0;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Bubbles must never carry live control (memory or register-file writes).
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .inc    (out_valid & ~out_ready),
        .clr    (cnt_clr),
        .count  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .inc    (~out_valid),
        .clr    (cnt_clr),
        .count  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance, no-skid instance and a
// narrow-counter instance, each with hand-computed expectations.
module tb_pipe_stage_reg;

    logic sysclk = 1'b0;
    logic reset;

    always #5 sysclk = ~sysclk;

    // Skid instance (SKID=1, CNT_W=16)
    logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1, cnt_clr1;
    logic [7:0]   in_ctrl1, out_ctrl1;
    logic [100:0] in_data1, out_data1;
    logic [15:0]  stall1, bubble1;

    // No-skid instance (SKID=0)
    logic         flush0, in_valid0, in_ready0, out_valid0, out_ready0, cnt_clr0;
    logic [7:0]   in_ctrl0, out_ctrl0;
    logic [100:0] in_data0, out_data0;
    logic [15:0]  stall0, bubble0;

    // Saturation instance (CNT_W=4)
    logic         flushs, in_valids, in_readys, out_valids, out_readys, cnt_clrs;
    logic [7:0]   in_ctrls, out_ctrls;
    logic [100:0] in_datas, out_datas;
    logic [3:0]   stalls, bubbles;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b1), .CNT_W(16)) dut_skid (
        .sysclk(sysclk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .cnt_clr(cnt_clr1), .stall_cnt(stall1), .bubble_cnt(bubble1)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b0), .CNT_W(16)) dut_noskid (
        .sysclk(sysclk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .cnt_clr(cnt_clr0), .stall_cnt(stall0), .bubble_cnt(bubble0)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b1), .CNT_W(4)) dut_sat (
        .sysclk(sysclk), .reset(reset), .flush(flushs),
        .in_valid(in_valids), .in_ready(in_readys), .in_ctrl(in_ctrls), .in_data(in_datas),
        .out_valid(out_valids), .out_ready(out_readys), .out_ctrl(out_ctrls), .out_data(out_datas),
        .cnt_clr(cnt_clrs), .stall_cnt(stalls), .bubble_cnt(bubbles)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then step clear of it before touching anything.
    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush1 = 0; in_valid1 = 1; in_ctrl1 = 8'hFF; in_data1 = 101'h55; out_ready1 = 1; cnt_clr1 = 0;
        flush0 = 0; in_valid0 = 1; in_ctrl0 = 8'hFF; in_data0 = 101'h55; out_ready0 = 1; cnt_clr0 = 0;
        flushs = 0; in_valids = 1; in_ctrls = 8'hFF; in_datas = 101'h55; out_readys = 1; cnt_clrs = 0;

        // Reset held two edges with in_valid asserted
        cyc();
        cyc();
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_ctrl", out_ctrl1, 0);
        check("rst_out_data", out_data1, 0);
        check("rst_stall", stall1, 0);
        check("rst_bubble", bubble1, 0);
        reset = 1'b0;
        in_valid1 = 0; in_valid0 = 0; in_valids = 0;
        cnt_clr1 = 1;
        #1;
        check("rst_in_ready", in_ready1, 1);

        // Streaming: beats 1..4 back to back, downstream always ready
        cyc();
        check("clr_stall", stall1, 0);
        check("clr_bubble", bubble1, 0);
        cnt_clr1 = 0;
        in_valid1 = 1; in_data1 = 101'h1; in_ctrl1 = 8'h81;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("stream_valid", out_valid1, 1);
            check("stream_data", out_data1, 128'(k));
            check("stream_ctrl", out_ctrl1, 128'(8'h80 | 8'(k)));
            check("stream_in_ready", in_ready1, 1);
            in_data1 = 101'(k + 1);
            in_ctrl1 = 8'h80 | 8'(k + 1);
        end
        in_valid1 = 0;
        check("stream_bubble", bubble1, 1);
        check("stream_stall", stall1, 0);
        cyc();
        check("drain_valid", out_valid1, 0);
        check("drain_ctrl", out_ctrl1, 0);

        // Stall with skid: A held, B skidded, C waits upstream
        out_ready1 = 0; in_valid1 = 1; in_data1 = 101'hA; in_ctrl1 = 8'h8A; cnt_clr1 = 1;
        cyc();
        cnt_clr1 = 0;
        check("stall_a_data", out_data1, 128'hA);
        check("stall_a_ready", in_ready1, 1);
        in_data1 = 101'hB; in_ctrl1 = 8'h8B;
        cyc();
        check("skid_b_data", out_data1, 128'hA);
        check("skid_b_ready", in_ready1, 0);
        check("skid_stall1", stall1, 1);
        in_data1 = 101'hC; in_ctrl1 = 8'h8C;
        cyc();
        check("skid_hold_ready", in_ready1, 0);
        cyc();
        check("skid_hold_data", out_data1, 128'hA);
        check("skid_hold_ctrl", out_ctrl1, 128'h8A);
        check("skid_stall3", stall1, 3);
        out_ready1 = 1;
        cyc();
        check("rel_b_data", out_data1, 128'hB);
        check("rel_b_ctrl", out_ctrl1, 128'h8B);
        check("rel_b_ready", in_ready1, 1);
        cyc();
        check("rel_c_data", out_data1, 128'hC);
        in_valid1 = 0;
        cyc();
        check("rel_empty", out_valid1, 0);
        check("rel_stall_kept", stall1, 3);

        // Flush while SKIDDED with a new beat offered
        out_ready1 = 0; in_valid1 = 1; in_data1 = 101'h11; in_ctrl1 = 8'h91;
        cyc();
        in_data1 = 101'h12; in_ctrl1 = 8'h92;
        cyc();
        check("fl_skidded_ready", in_ready1, 0);
        in_data1 = 101'h13; in_ctrl1 = 8'h93; flush1 = 1;
        cyc();
        check("fl_valid", out_valid1, 0);
        check("fl_ctrl", out_ctrl1, 0);
        check("fl_data", out_data1, 0);
        check("fl_in_ready", in_ready1, 1);
        check("fl_stall_kept", stall1, 5);
        flush1 = 0; in_valid1 = 0; out_ready1 = 1;
        cyc();
        check("fl_no_old_1", out_valid1, 0);
        cyc();
        check("fl_no_old_2", out_valid1, 0);
        in_valid1 = 1; in_data1 = 101'h21; in_ctrl1 = 8'hA1;
        cyc();
        check("fl_new_data", out_data1, 128'h21);
        check("fl_new_ctrl", out_ctrl1, 128'hA1);
        in_valid1 = 0;

        // No-skid: in_ready follows !out_valid | out_ready combinationally
        in_valid0 = 1; in_data0 = 101'h31; in_ctrl0 = 8'hB1; out_ready0 = 1;
        #1;
        check("ns_ready_empty", in_ready0, 1);
        cyc();
        check("ns_data_31", out_data0, 128'h31);
        in_data0 = 101'h32; in_ctrl0 = 8'hB2; out_ready0 = 0;
        #1;
        check("ns_ready_stall", in_ready0, 0);
        cyc();
        check("ns_hold_31", out_data0, 128'h31);
        check("ns_hold_ctrl", out_ctrl0, 128'hB1);
        out_ready0 = 1;
        #1;
        check("ns_ready_resume", in_ready0, 1);
        cyc();
        check("ns_data_32", out_data0, 128'h32);
        in_valid0 = 0;
        cyc();
        check("ns_empty", out_valid0, 0);
        check("ns_empty_ready", in_ready0, 1);

        // Saturation with a 4-bit counter
        in_valids = 1; in_datas = 101'h41; in_ctrls = 8'hC1; out_readys = 0; cnt_clrs = 1;
        cyc();
        cnt_clrs = 0; in_valids = 0;
        repeat (20) cyc();
        check("sat_stall_15", stalls, 15);
        check("sat_bubble_0", bubbles, 0);
        check("sat_data_held", out_datas, 128'h41);
        cyc();
        check("sat_stall_hold", stalls, 15);
        cnt_clrs = 1;
        cyc();
        check("sat_clr_wins", stalls, 0);
        cnt_clrs = 0;
        cyc();
        check("sat_restart", stalls, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
